const_mem_writer: RTL and testbench

Write-side companion to the constant memory: accepts 4-lane constant store requests from the ID/EX stage over a valid/ready handshake and drives the memory's single write port one 32-bit word per cycle. It provides the path that fills constant memory at run time. The memory's four asynchronous read ports are the consumer side.

---
 rtl/const_mem_writer_if.sv | 11 +
 rtl/const_mem_writer.sv | 120 ++++++++++++
 tb/tb_const_mem_writer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/const_mem_writer_if.sv
// Store-request handshake between the ID/EX stage (master) and the constant memory writer (slave).
interface const_mem_writer_if;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic [127:0] req_data;
  logic [3:0]   req_mask;

  modport master (output req_valid, req_addr, req_data, req_mask, input req_ready);
  modport slave  (input req_valid, req_addr, req_data, req_mask, output req_ready);
endinterface

// File: rtl/const_mem_writer.sv
// Turns 4-lane constant store requests into one 32-bit constant memory write per cycle.
// Define CONST_WR_RANGE_CHECK_EN to suppress out-of-range lanes and raise a sticky err flag.
module const_mem_writer #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  const_mem_writer_if.slave    req,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_waddr,
  output logic [31:0]          mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic                 err_clr
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t       state;
  logic [31:0]  addr_q;
  logic [127:0] data_q;
  logic [3:0]   pend;

  logic [3:0]   src_mask;
  logic [31:0]  src_addr;
  logic [127:0] src_data;
  logic [1:0]   lane;
  logic [31:0]  lane_addr;
  logic [31:0]  lane_data;
  logic         lane_ok;
  logic         emit;

  assign req.req_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

  // The first lane is launched straight from the request so mem_we rises the cycle after accept.
  always_comb begin
    src_mask = pend;
    src_addr = addr_q;
    src_data = data_q;
    if (state == IDLE) begin
      src_mask = req.req_mask;
      src_addr = req.req_addr;
      src_data = req.req_data;
    end
    lane = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (src_mask[i]) lane = 2'(i);
    end
    lane_addr = src_addr + {30'd0, lane};
    lane_data = src_data[32*lane +: 32];
    emit      = ((state == IDLE) && req.req_valid && (req.req_mask != 4'd0)) ||
                ((state == WRITE) && (pend != 4'd0));
  end

`ifdef CONST_WR_RANGE_CHECK_EN
  logic oor_q;

  assign lane_ok = (lane_addr < 32'(DEPTH));

  // A suppressed lane raises err one cycle after its slot; clearing wins over setting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oor_q <= 1'b0;
      err   <= 1'b0;
    end else begin
      oor_q <= emit && !lane_ok;
      if (err_clr)
        err <= 1'b0;
      else if (oor_q)
        err <= 1'b1;
    end
  end
`else
  logic          unused_err_clr;
  logic [31-AW:0] unused_addr_hi;

  assign lane_ok        = 1'b1;
  assign err            = 1'b0;
  assign unused_err_clr = err_clr;
  assign unused_addr_hi = lane_addr[31:AW];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= 32'd0;
      data_q    <= 128'd0;
      pend      <= 4'd0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= 32'd0;
    end else begin
      mem_we <= emit && lane_ok;
      if (emit) begin
        mem_waddr <= lane_addr[AW-1:0];
        mem_wdata <= lane_data;
        pend      <= src_mask & ~(4'b0001 << lane);
      end
      case (state)
        IDLE: begin
          if (req.req_valid) begin
            addr_q <= req.req_addr;
            data_q <= req.req_data;
            state  <= (req.req_mask != 4'd0) ? WRITE : DONE;
          end
        end
        WRITE: begin
          if (pend == 4'd0) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_const_mem_writer.sv
// Self-checking bench for const_mem_writer: vector table, hand-written corner sequences and random requests.
module tb_const_mem_writer;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
`ifdef CONST_WR_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          err_clr = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          busy, done, err;

  const_mem_writer_if bus ();

  const_mem_writer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  logic err_model = 1'b0;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
    logic [3:0]   mask;
    int           exp_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkFlag(input string name, input logic act, input logic exp);
    checkOutput(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Drives one request and checks every cycle against the lane list derived from the mask.
  task automatic applyStimulus(input logic [31:0] addr, input logic [127:0] data,
                               input logic [3:0] mask, output int lat);
    int          wait_n;
    int          cnt;
    int          lanes[$];
    logic [31:0] a;
    bit          sup;
    wait_n = 0;
    lat = -1;
    while (bus.req_ready !== 1'b1 && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    checkFlag("ready_before_req", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_data  = data;
    bus.req_mask  = mask;
    for (int i = 0; i < 4; i++) if (mask[i]) lanes.push_back(i);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_data  = {$urandom, $urandom, $urandom, $urandom};
    bus.req_mask  = 4'($urandom);
    foreach (lanes[k]) begin
      a   = addr + 32'(lanes[k]);
      sup = RANGE_CHK && (a >= 32'(DEPTH));
      checkFlag("err_in_write", err, err_model);
      checkFlag("we", mem_we, !sup);
      if (!sup) begin
        checkOutput("waddr", 32'(mem_waddr), {22'd0, a[AW-1:0]});
        checkOutput("wdata", mem_wdata, data[32*lanes[k] +: 32]);
      end
      checkFlag("ready_in_write", bus.req_ready, 1'b0);
      checkFlag("busy_in_write", busy, 1'b1);
      if (sup) err_model = 1'b1;
      @(negedge clk);
    end
    cnt = lanes.size() + 1;
    while (done !== 1'b1 && cnt < lanes.size() + 8) begin
      @(negedge clk);
      cnt++;
    end
    if (done === 1'b1) lat = cnt;
    checkFlag("we_at_done", mem_we, 1'b0);
    checkFlag("ready_at_done", bus.req_ready, 1'b0);
    checkFlag("err_at_done", err, err_model);
    @(negedge clk);
    checkFlag("ready_after_done", bus.req_ready, 1'b1);
    checkFlag("done_after_done", done, 1'b0);
    checkFlag("busy_after_done", busy, 1'b0);
  endtask

  task automatic checkResetValues(input string tag);
    checkFlag({tag, "_we"}, mem_we, 1'b0);
    checkOutput({tag, "_waddr"}, 32'(mem_waddr), 32'd0);
    checkOutput({tag, "_wdata"}, mem_wdata, 32'd0);
    checkFlag({tag, "_busy"}, busy, 1'b0);
    checkFlag({tag, "_done"}, done, 1'b0);
    checkFlag({tag, "_err"}, err, 1'b0);
    checkFlag({tag, "_ready"}, bus.req_ready, 1'b1);
  endtask

  task automatic pulseErrClr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    err_model = 1'b0;
    checkFlag("err_after_clr", err, 1'b0);
  endtask

  initial begin
    int          lat;
    int          stray;
    logic [31:0] ra;
    logic [3:0]  rm;

    bus.req_valid = 1'b0;
    bus.req_addr  = 32'd0;
    bus.req_data  = 128'd0;
    bus.req_mask  = 4'd0;

    vecs[0] = '{32'h10,  {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'hF,    5};
    vecs[1] = '{32'h20,  {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 4'b1010, 3};
    vecs[2] = '{32'h55,  {32'h1, 32'h2, 32'h3, 32'h4},     4'h0,    1};
    vecs[3] = '{32'h100, {32'h5, 32'h6, 32'h7, 32'hCAFE},  4'b0001, 2};
    vecs[4] = '{32'h3FE, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 4'hF,    5};

    repeat (2) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Vectors 2 and 3 run back to back: the zero-mask request frees the port at T+2.
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].addr, vecs[v].data, vecs[v].mask, lat);
      checkOutput($sformatf("done_latency_vec%0d", v), 32'(lat), 32'(vecs[v].exp_lat));
    end
    checkFlag("err_after_range_edge", err, RANGE_CHK);
    pulseErrClr();

    // Reset in the middle of a full store, right after the second write.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h40;
    bus.req_data  = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    bus.req_mask  = 4'hF;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput("midrst_first_waddr", 32'(mem_waddr), 32'h40);
    @(negedge clk);
    checkFlag("midrst_second_we", mem_we, 1'b1);
    checkOutput("midrst_second_waddr", 32'(mem_waddr), 32'h41);
    #2 rst_n = 1'b0;
    #1 checkResetValues("async_reset");
    err_model = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 5; c++) begin
      if (mem_we === 1'b1 || done === 1'b1) stray++;
      @(negedge clk);
    end
    checkOutput("no_activity_after_reset", 32'(stray), 32'd0);
    applyStimulus(32'h200, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 4'b0110, lat);
    checkOutput("latency_after_reset", 32'(lat), 32'd3);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       ra = 32'($urandom_range(0, DEPTH - 1));
        1:       ra = 32'(DEPTH - 4) + 32'($urandom_range(0, 7));
        2:       ra = $urandom;
        default: ra = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      endcase
      rm = 4'($urandom_range(0, 15));
      applyStimulus(ra, {$urandom, $urandom, $urandom, $urandom}, rm, lat);
      checkOutput("rand_latency", 32'(lat), 32'($countones(rm) + 1));
      if ($urandom_range(0, 3) == 0) pulseErrClr();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
